// File: rtl/dram_responder.sv
// Memory-side responder for the tile DRAM protocol: line-organised array, in-order read queue
// with fixed minimum latency, and a sticky misalignment flag. Optional macro: DRAM_RESP_BACKPRESSURE_EN.
module dram_responder #(
    parameter int GBW     = 32,
    parameter int DBW     = 16,
    parameter int CSIZE   = 32,
    parameter int MEM_ABW = 8,
    parameter int RLAT    = 4,
    parameter int QDEPTH  = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_dramra_rdy,
    output logic                   o_dramra_ack,
    input  logic [GBW-1:0]         i_dramra,
    output logic                   o_dramrd_rdy,
    input  logic                   i_dramrd_ack,
    output logic [CSIZE*DBW-1:0]   o_dramrd,
    input  logic                   i_dramw_rdy,
    output logic                   o_dramw_ack,
    input  logic [GBW-1:0]         i_dramwa,
    input  logic [CSIZE*DBW-1:0]   i_dramwd,
    input  logic [CSIZE-1:0]       i_dramw_mask,
    output logic                   o_err
);
    localparam int CL_BW = $clog2(CSIZE);
    localparam int LW    = CSIZE * DBW;
    localparam int QW    = $clog2(QDEPTH);
    localparam int AW    = $clog2(RLAT + 1);
    localparam int DEPTH = 1 << MEM_ABW;
    localparam logic [QW:0]   QFULL   = (QW + 1)'(QDEPTH);
    localparam logic [AW-1:0] AGE_MAX = AW'(RLAT);

    // Handshake: a transfer happens on the edge where rdy && ack; the source holds rdy and its
    // payload stable until ack. Acks depend only on i_*_rdy and registered state.
    logic [LW-1:0] mem  [DEPTH];
    logic [LW-1:0] snap [QDEPTH];
    logic [AW-1:0] age  [QDEPTH];
    logic [QW-1:0] rptr, wptr;
    logic [QW:0]   count;
    logic          err_q;
    logic          ack_gate;
    logic          ra_fire, w_fire, pop;
    logic [MEM_ABW-1:0] ridx, widx;
    logic          unused_addr;

`ifdef DRAM_RESP_BACKPRESSURE_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr[14:0], lfsr_fb};
    end

    assign ack_gate = ~lfsr[0];
`else
    assign ack_gate = 1'b1;
`endif

    assign ridx        = i_dramra[CL_BW +: MEM_ABW];
    assign widx        = i_dramwa[CL_BW +: MEM_ABW];
    assign unused_addr = ^{i_dramra[GBW-1:CL_BW+MEM_ABW], i_dramwa[GBW-1:CL_BW+MEM_ABW]};

    assign o_dramw_ack  = i_dramw_rdy && !i_rst && ack_gate;
    assign o_dramra_ack = i_dramra_rdy && !i_rst && ack_gate && (count < QFULL);
    assign ra_fire      = i_dramra_rdy && o_dramra_ack;
    assign w_fire       = i_dramw_rdy && o_dramw_ack;

    assign o_dramrd_rdy = (count != '0) && (age[rptr] == AGE_MAX);
    assign o_dramrd     = (count != '0) ? snap[rptr] : '0;
    assign pop          = o_dramrd_rdy && i_dramrd_ack;
    assign o_err        = err_q;

    // Array and snapshots carry no reset; snapshot reads mem before this edge's write lands.
    always_ff @(posedge i_clk) begin
        if (w_fire) begin
            for (int k = 0; k < CSIZE; k++) begin
                if (i_dramw_mask[k]) mem[widx][k*DBW +: DBW] <= i_dramwd[k*DBW +: DBW];
            end
        end
        if (ra_fire) snap[wptr] <= mem[ridx];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < QDEPTH; i++) age[i] <= '0;
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (ra_fire && (wptr == QW'(i))) age[i] <= '0;
                else if (age[i] != AGE_MAX)      age[i] <= age[i] + AW'(1);
            end
            if (ra_fire) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            case ({ra_fire, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if ((ra_fire && (i_dramra[CL_BW-1:0] != '0)) ||
                (w_fire  && (i_dramwa[CL_BW-1:0] != '0)))
                err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dram_responder.sv
// Directed bench for dram_responder: drivers push expected lines, a negedge monitor pops and compares.
module tb_dram_responder;
    localparam int GBW   = 32;
    localparam int DBW   = 16;
    localparam int CSIZE = 32;
    localparam int LW    = CSIZE * DBW;

    logic             clk, rst;
    logic             i_dramra_rdy, o_dramra_ack;
    logic [GBW-1:0]   i_dramra;
    logic             o_dramrd_rdy, i_dramrd_ack;
    logic [LW-1:0]    o_dramrd;
    logic             i_dramw_rdy, o_dramw_ack;
    logic [GBW-1:0]   i_dramwa;
    logic [LW-1:0]    i_dramwd;
    logic [CSIZE-1:0] i_dramw_mask;
    logic             o_err;

    int errors = 0;
    int checks = 0;
    logic [LW-1:0] exp_q[$];
    logic [LW-1:0] line3;

    dram_responder dut (
        .i_clk(clk), .i_rst(rst),
        .i_dramra_rdy(i_dramra_rdy), .o_dramra_ack(o_dramra_ack), .i_dramra(i_dramra),
        .o_dramrd_rdy(o_dramrd_rdy), .i_dramrd_ack(i_dramrd_ack), .o_dramrd(o_dramrd),
        .i_dramw_rdy(i_dramw_rdy), .o_dramw_ack(o_dramw_ack), .i_dramwa(i_dramwa),
        .i_dramwd(i_dramwd), .i_dramw_mask(i_dramw_mask), .o_err(o_err)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [LW-1:0] fill(input logic [15:0] base);
        logic [LW-1:0] l;
        for (int k = 0; k < CSIZE; k++) l[k*DBW +: DBW] = base + 16'(k);
        return l;
    endfunction

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Driver tasks: start and end 1 time unit after a rising edge
    task automatic do_write(input logic [GBW-1:0] addr, input logic [LW-1:0] data,
                            input logic [CSIZE-1:0] mask);
        int n = 0;
        bit done = 1'b0;
        i_dramw_rdy = 1'b1; i_dramwa = addr; i_dramwd = data; i_dramw_mask = mask;
        while (!done && n < 50) begin
            @(negedge clk);
            if (o_dramw_ack) done = 1'b1;
            tick(1);
            n++;
        end
        i_dramw_rdy = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL write_timeout: addr %0h not acked", addr);
        end
    endtask

    task automatic do_read(input logic [GBW-1:0] addr, input logic [LW-1:0] exp);
        int n = 0;
        bit done = 1'b0;
        i_dramra_rdy = 1'b1; i_dramra = addr;
        while (!done && n < 50) begin
            @(negedge clk);
            if (o_dramra_ack) begin
                done = 1'b1;
                exp_q.push_back(exp);
            end
            tick(1);
            n++;
        end
        i_dramra_rdy = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL read_timeout: addr %0h not acked", addr);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            tick(1);
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d reads outstanding", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && o_dramrd_rdy && i_dramrd_ack) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_return: got %0h with no read outstanding", o_dramrd);
            end else begin
                check("read_data", o_dramrd, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        i_dramra_rdy = 1'b1; i_dramra = '0;
        i_dramw_rdy = 1'b1;  i_dramwa = '0; i_dramwd = '0; i_dramw_mask = '0;
        i_dramrd_ack = 1'b0;
        tick(2);
        check("rst_rd_rdy", LW'(o_dramrd_rdy), LW'(0));
        check("rst_rd_data", o_dramrd, '0);
        check("rst_err", LW'(o_err), LW'(0));
        check("rst_ra_ack", LW'(o_dramra_ack), LW'(0));
        check("rst_w_ack", LW'(o_dramw_ack), LW'(0));
        i_dramra_rdy = 1'b0; i_dramw_rdy = 1'b0;
        rst = 1'b0;
        tick(1);

        // Full write and read latency of line 3
        do_write(32'h60, fill(16'h100), '1);
        do_read(32'h60, fill(16'h100));
        check("lat_0", LW'(o_dramrd_rdy), LW'(0));
        for (int i = 1; i < 4; i++) begin
            tick(1);
            check($sformatf("lat_%0d", i), LW'(o_dramrd_rdy), LW'(0));
        end
        tick(1);
        check("lat_4", LW'(o_dramrd_rdy), LW'(1));
        i_dramrd_ack = 1'b1;
        tick(1);
        check("pop_rdy_drop", LW'(o_dramrd_rdy), LW'(0));
        check("empty_data", o_dramrd, '0);

        // Masked write: words 0 and 2 only
        do_write(32'h60, {CSIZE{16'hBEEF}}, 32'h0000_0005);
        line3 = fill(16'h100);
        line3[0 +: DBW]     = 16'hBEEF;
        line3[2*DBW +: DBW] = 16'hBEEF;
        do_read(32'h60, line3);
        wait_drain();

        // Queue full: fifth read stalls until one pop
        for (int i = 8; i < 13; i++) do_write(GBW'(i * 32), fill(16'(16'h2000 + i * 16'h100)), '1);
        i_dramrd_ack = 1'b0;
        for (int i = 8; i < 12; i++) do_read(GBW'(i * 32), fill(16'(16'h2000 + i * 16'h100)));
        i_dramra_rdy = 1'b1; i_dramra = 32'd384;
        @(negedge clk);
        check("full_stall", LW'(o_dramra_ack), LW'(0));
        tick(2);
        i_dramrd_ack = 1'b1;
        @(negedge clk);
        check("full_pop_same_edge", LW'(o_dramra_ack), LW'(0));
        tick(1);
        @(negedge clk);
        check("after_pop_ack", LW'(o_dramra_ack), LW'(1));
        if (o_dramra_ack) exp_q.push_back(fill(16'h2000 + 16'hC00));
        tick(1);
        i_dramra_rdy = 1'b0;
        wait_drain();

        // Same-edge write and read of line 5
        do_write(32'hA0, fill(16'h500), '1);
        i_dramw_rdy = 1'b1; i_dramwa = 32'hA0; i_dramwd = fill(16'h5A0); i_dramw_mask = '1;
        i_dramra_rdy = 1'b1; i_dramra = 32'hA0;
        @(negedge clk);
        check("same_edge_w_ack", LW'(o_dramw_ack), LW'(1));
        check("same_edge_ra_ack", LW'(o_dramra_ack), LW'(1));
        if (o_dramra_ack) exp_q.push_back(fill(16'h500));
        tick(1);
        i_dramw_rdy = 1'b0; i_dramra_rdy = 1'b0;
        wait_drain();
        do_read(32'hA0, fill(16'h5A0));
        wait_drain();

        // Misaligned read sets the sticky error
        check("err_before", LW'(o_err), LW'(0));
        do_read(32'h61, line3);
        check("err_set", LW'(o_err), LW'(1));
        wait_drain();
        tick(3);
        check("err_sticky", LW'(o_err), LW'(1));

        // Reset with two reads pending and data presented
        i_dramrd_ack = 1'b0;
        do_read(32'h60, line3);
        do_read(32'hA0, fill(16'h5A0));
        tick(4);
        check("pre_reset_rdy", LW'(o_dramrd_rdy), LW'(1));
        i_dramra_rdy = 1'b1; i_dramra = 32'h60;
        #2;
        rst = 1'b1;
        #1;
        check("reset_rd_rdy", LW'(o_dramrd_rdy), LW'(0));
        check("reset_rd_data", o_dramrd, '0);
        check("reset_err", LW'(o_err), LW'(0));
        check("reset_ra_ack", LW'(o_dramra_ack), LW'(0));
        exp_q.delete();
        i_dramra_rdy = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(6);
        check("post_reset_rd_rdy", LW'(o_dramrd_rdy), LW'(0));
        i_dramrd_ack = 1'b1;
        do_read(32'h60, line3);
        wait_drain();
        tick(1);
        check("final_empty", LW'(o_dramrd_rdy), LW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dram_responder.md
Name: dram_responder

Overview:
- Memory-side end of the tile DRAM protocol: accepts read addresses (dramra), returns full cache lines (dramrd), and accepts masked line writes (dramw).
- Sits behind the DRAM arbiter/write pipeline of a tile; used as the simulation/FPGA DRAM model and as the protocol reference responder.
- Holds a line-organised memory array, an in-order read queue with fixed minimum latency, and a sticky alignment-error flag.

Parameters:
- GBW, 32, global address width (bits).
- DBW, 16, data word width.
- CSIZE, 32, words per line; power of two; CL_BW = log2(CSIZE).
- MEM_ABW, 8, line index width; array depth = 2^MEM_ABW lines.
- RLAT, 4, minimum read latency in cycles; must be >= 1.
- QDEPTH, 4, read queue entries; power of two.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_dramra_rdy  in  1  read address valid
- o_dramra_ack  out  1  read address accepted
- i_dramra  in  GBW  read address (word address)
- o_dramrd_rdy  out  1  read data valid
- i_dramrd_ack  in  1  read data consumed
- o_dramrd  out  CSIZE*DBW  line data, word k at bits [k*DBW +: DBW]
- i_dramw_rdy  in  1  write valid
- o_dramw_ack  out  1  write accepted
- i_dramwa  in  GBW  write address (word address)
- i_dramwd  in  CSIZE*DBW  write line data
- i_dramw_mask  in  CSIZE  per-word write enable, bit k for word k
- o_err  out  1  sticky misaligned-address flag

Behaviour:
- Handshake: transfer occurs on the edge where rdy && ack. Source holds rdy and data stable until ack. Ack is never high without rdy.
- Acks are combinational from i_*_rdy and registered state only; never from i_dramrd_ack. This avoids a comb path through the queue.
- Line index = addr[CL_BW +: MEM_ABW]; address bits above CL_BW+MEM_ABW are ignored.
- Any accepted read or write address with addr[CL_BW-1:0] != 0 sets o_err (sticky until reset). The access still proceeds with the truncated index.
- Write: o_dramw_ack = i_dramw_rdy. On a transfer edge, each word k with mask[k]=1 is written; words with mask bit 0 keep their value. A mask of all zeros is a legal no-op that is still acked.
- Read accept: o_dramra_ack = i_dramra_rdy && (count < QDEPTH). On the accept edge, the entry stores a snapshot of the current array line and sets age = 0.
- Age: each entry's age increments every subsequent edge and saturates at RLAT.
- Read return: the queue is in order. o_dramrd_rdy = (count > 0) && (head age == RLAT). o_dramrd = head snapshot, and is 0 when the queue is empty. Pop on i_dramrd_ack && o_dramrd_rdy.
- Latency: address accepted at edge N → o_dramrd_rdy high after edge N+RLAT at the earliest; back-to-back accepts give back-to-back returns.
- Simultaneous events:
  - Write and read of the same line on the same edge: the read snapshot holds the pre-write data.
  - Push and pop on the same edge: count is unchanged.
  - A full queue with a pop that edge still refuses the push; ack is recomputed the next cycle.
- Pointers: read/write pointers are log2(QDEPTH) bits and wrap naturally. count is log2(QDEPTH)+1 bits, range 0..QDEPTH.
- Reset (async, any time, including mid-transfer):
  - count, pointers and ages are cleared; o_dramrd_rdy=0; o_dramrd=0; o_err=0.
  - Acks are held 0 while i_rst is high.
  - Pending reads are discarded.
  - Array contents are not reset and are undefined until written.

Optional Feature:
- Macro DRAM_RESP_BACKPRESSURE_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) advances every cycle. While lfsr[0]=1, o_dramra_ack and o_dramw_ack are forced 0. The read-return path is unaffected.
- Undefined: no LFSR exists and the ack equations are exactly as above.

Test Plan:
- Write line 3 (addr 0x60), mask all-ones, word k = k+0x100; read addr 0x60 accepted at edge 10 → o_dramrd_rdy first high after edge 14 with word k = k+0x100; pop on ack; rdy drops.
- Partial write line 3, mask 32'h0000_0005, data all 0xBEEF → read returns word0 = word2 = 0xBEEF, other words unchanged (k+0x100).
- Hold i_dramrd_ack=0 and issue 5 reads → first 4 acked; 5th stalls with o_dramra_ack=0; one pop → 5th acked on the following cycle; all 5 return in issue order.
- Same-edge write of line 5 (new data) and read of 0xA0 → returned line is the old data; a later read returns the new data.
- Read addr 0x61 → o_err=1 and stays high; data returned is line 3; o_err clears only on reset.
- Reset asserted with 2 pending reads while rdy is high → o_dramrd_rdy=0 immediately and stays 0 after reset release; the queue is empty and the next read completes normally.
